gdiv_u_acc: RTL and testbench



---
 rtl/gdiv_u_acc.sv | 128 ++++++++++++
 tb/tb_gdiv_u_acc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gdiv_u_acc.sv
// Converts the stochastic divider's unary quotient stream into a binary ones count
// over a 2^WIN_W-cycle window, after a programmable warm-up, with a valid/ready result port.
module gdiv_u_acc #(
    parameter int unsigned WIN_W = 8,
    parameter int unsigned WARM  = 16,
    parameter int unsigned OUT_W = WIN_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_bit,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result,
    output logic             overrun
);

    localparam int unsigned    WCW       = (WARM < 1) ? 1 : $clog2(WARM + 1);
    localparam logic [WCW-1:0] WARM_LAST = WCW'((WARM > 0) ? (WARM - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WARM,
        S_ACC,
        S_HOLD
    } state_t;

    // With no warm-up an accepted start goes straight into accumulation.
    localparam state_t FIRST = (WARM == 0) ? S_ACC : S_WARM;

    state_t           state;
    state_t           state_next;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_sum;
    logic [WCW-1:0]   warm_cnt;
    logic [WIN_W-1:0] win_cnt;
    logic             accept;
    logic             stray;
    logic             warm_done;
    logic             win_done;

    assign acc_sum   = acc + OUT_W'(in_bit);
    assign warm_done = (warm_cnt == WARM_LAST);
    assign win_done  = (win_cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        stray      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = FIRST;
                end
            end
            S_WARM: begin
                busy  = 1'b1;
                stray = start;
                if (warm_done) begin
                    state_next = S_ACC;
                end
            end
            S_ACC: begin
                busy  = 1'b1;
                stray = start;
                if (win_done) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                // A start coinciding with the transfer restarts without an idle bubble.
                if (out_ready) begin
                    if (start) begin
                        accept     = 1'b1;
                        state_next = FIRST;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            warm_cnt <= '0;
            win_cnt  <= '0;
            result   <= '0;
            overrun  <= 1'b0;
        end else if (accept) begin
            acc      <= '0;
            warm_cnt <= '0;
            win_cnt  <= '0;
            overrun  <= 1'b0;
        end else begin
            if (stray) begin
                overrun <= 1'b1;
            end
            if (state == S_WARM) begin
                warm_cnt <= warm_cnt + WCW'(1);
            end
            if (state == S_ACC) begin
                acc     <= acc_sum;
                win_cnt <= win_cnt + WIN_W'(1);
                // The final sample is folded into the published count on the same edge.
                if (win_done) begin
                    result <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_gdiv_u_acc.sv
// Randomised self-checking bench for gdiv_u_acc: a window-counting model predicts
// latency and ones count for each conversion and the bench compares the DUT against it.
module tb_gdiv_u_acc;

    localparam int WIN_W = 8;
    localparam int WARM  = 16;
    localparam int N     = 1 << WIN_W;
    localparam int OUT_W = WIN_W + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             in_bit;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] result;
    logic             overrun;

    int checks   = 0;
    int failures = 0;

    gdiv_u_acc #(
        .WIN_W(WIN_W),
        .WARM (WARM)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_bit   (in_bit),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    // Stream value sampled at edge c after the start edge (edge 0).
    function automatic logic bit_for(input int mode, input int c);
        case (mode)
            0: return 1'b1;
            1: return 1'b0;
            2: return (c >= WARM + 1) ? (((c - WARM - 1) % 2) == 0) : 1'b0;
            3: return (c >= 1 && c <= WARM);
            default: return 1'($urandom % 2);
        endcase
    endfunction

    // Drives one conversion from a negedge; the model counts the ones presented at
    // edges WARM+1..WARM+N, and out_valid is expected right after edge WARM+N.
    task automatic conversion(input int mode, input int stray_at, input int abort_at,
                              output int lat, output int exp_cnt, output int busy_gaps,
                              output logic v1, output logic b1, output logic ovr1);
        logic b;
        lat       = -1;
        exp_cnt   = 0;
        busy_gaps = 0;
        start     = 1'b1;
        in_bit    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        v1    = out_valid;
        b1    = busy;
        ovr1  = overrun;
        for (int c = 1; c <= WARM + N + 40; c++) begin
            if (abort_at != 0 && c == abort_at) return;
            b      = bit_for(mode, c);
            in_bit = b;
            start  = (c == stray_at);
            if (c >= WARM + 1 && c <= WARM + N) exp_cnt += int'(b);
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (out_valid) begin
                lat = c;
                break;
            end
            if (!busy) busy_gaps++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%0d want=0", result); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        int lat, exp_cnt, gaps;
        logic v1, b1, o1;
        out_ready = 1'b1;
        conversion(0, 0, 0, lat, exp_cnt, gaps, v1, b1, o1);
        checks++; if (v1 !== 1'b0 || b1 !== 1'b1) begin failures++; $display("FAIL ones_first_cycle got valid=%b busy=%b want valid=0 busy=1", v1, b1); end
        checks++; if (lat !== WARM + N) begin failures++; $display("FAIL ones_latency got=%0d want=%0d", lat, WARM + N); end
        checks++; if (result !== OUT_W'(exp_cnt)) begin failures++; $display("FAIL ones_result got=%0d want=%0d", result, exp_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ones_busy_with_valid got=%b want=0", busy); end
        checks++; if (gaps !== 0) begin failures++; $display("FAIL ones_busy_gaps got=%0d want=0", gaps); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ones_after_xfer got valid=%b busy=%b want 0 0", out_valid, busy); end
        checks++; if (result !== OUT_W'(N)) begin failures++; $display("FAIL ones_result_kept got=%0d want=%0d", result, N); end
    endtask

    task automatic test_patterns();
        int lat, exp_cnt, gaps;
        logic v1, b1, o1;
        out_ready = 1'b1;
        for (int mode = 1; mode <= 3; mode++) begin
            conversion(mode, 0, 0, lat, exp_cnt, gaps, v1, b1, o1);
            checks++; if (lat !== WARM + N) begin failures++; $display("FAIL pattern%0d_latency got=%0d want=%0d", mode, lat, WARM + N); end
            checks++; if (result !== OUT_W'(exp_cnt)) begin failures++; $display("FAIL pattern%0d_result got=%0d want=%0d", mode, result, exp_cnt); end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int lat, exp_cnt, gaps;
        logic v1, b1, o1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            conversion(4, 0, 0, lat, exp_cnt, gaps, v1, b1, o1);
            checks++; if (lat !== WARM + N) begin failures++; $display("FAIL random%0d_latency got=%0d want=%0d", i, lat, WARM + N); end
            checks++; if (result !== OUT_W'(exp_cnt)) begin failures++; $display("FAIL random%0d_result got=%0d want=%0d", i, result, exp_cnt); end
            repeat (1 + $urandom_range(0, 3)) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat, exp_cnt, gaps;
        logic v1, b1, o1;
        out_ready = 1'b0;
        conversion(4, 0, 0, lat, exp_cnt, gaps, v1, b1, o1);
        checks++; if (lat !== WARM + N) begin failures++; $display("FAIL hold_latency got=%0d want=%0d", lat, WARM + N); end
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            checks++; if (out_valid !== 1'b1 || result !== OUT_W'(exp_cnt)) begin failures++; $display("FAIL hold_stable%0d got valid=%b result=%0d want valid=1 result=%0d", i, out_valid, result, exp_cnt); end
        end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL hold_start_no_overrun got=%b want=0", overrun); end
        out_ready = 1'b1;
        conversion(4, 0, 0, lat, exp_cnt, gaps, v1, b1, o1);
        checks++; if (v1 !== 1'b0 || b1 !== 1'b1) begin failures++; $display("FAIL b2b_restart got valid=%b busy=%b want valid=0 busy=1", v1, b1); end
        checks++; if (lat !== WARM + N) begin failures++; $display("FAIL b2b_latency got=%0d want=%0d", lat, WARM + N); end
        checks++; if (result !== OUT_W'(exp_cnt)) begin failures++; $display("FAIL b2b_result got=%0d want=%0d", result, exp_cnt); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_overrun();
        int lat, exp_cnt, gaps;
        logic v1, b1, o1;
        out_ready = 1'b1;
        conversion(4, 100, 0, lat, exp_cnt, gaps, v1, b1, o1);
        checks++; if (lat !== WARM + N) begin failures++; $display("FAIL ovr_latency got=%0d want=%0d", lat, WARM + N); end
        checks++; if (result !== OUT_W'(exp_cnt)) begin failures++; $display("FAIL ovr_result got=%0d want=%0d", result, exp_cnt); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b want=1", overrun); end
        checks++; if (gaps !== 0) begin failures++; $display("FAIL ovr_busy_gaps got=%0d want=0", gaps); end
        conversion(4, 0, 0, lat, exp_cnt, gaps, v1, b1, o1);
        checks++; if (o1 !== 1'b0) begin failures++; $display("FAIL ovr_cleared got=%b want=0", o1); end
        checks++; if (result !== OUT_W'(exp_cnt)) begin failures++; $display("FAIL ovr_next_result got=%0d want=%0d", result, exp_cnt); end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int lat, exp_cnt, gaps;
        logic v1, b1, o1;
        out_ready = 1'b1;
        conversion(0, 60, 150, lat, exp_cnt, gaps, v1, b1, o1);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0) begin failures++; $display("FAIL midrst_flags got busy=%b valid=%b ovr=%b want 0 0 0", busy, out_valid, overrun); end
        checks++; if (result !== '0) begin failures++; $display("FAIL midrst_result got=%0d want=0", result); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL midrst_idle got busy=%b valid=%b want 0 0", busy, out_valid); end
        conversion(4, 0, 0, lat, exp_cnt, gaps, v1, b1, o1);
        checks++; if (lat !== WARM + N) begin failures++; $display("FAIL midrst_latency got=%0d want=%0d", lat, WARM + N); end
        checks++; if (result !== OUT_W'(exp_cnt)) begin failures++; $display("FAIL midrst_result_after got=%0d want=%0d", result, exp_cnt); end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_random();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
